clk_sched_ctrl: RTL and testbench
=================================

CLK_SCHED_CTRL -- requirements
Module: clk_sched_ctrl

Interface
REQ-001 Parameter: DIV_W, default 8, width of the divide-ratio fields.
REQ-002 Parameter: TICK_W, default 16, width of the processor-tick counter.
REQ-003 CLK  in  1  system clock; all state updates on its rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 run  in  1  level; request processor enable pulses to run continuously.
REQ-006 step  in  1  level, sampled each cycle; request exactly one processor enable pulse.
REQ-007 halt_req  in  1  level; request a halt on the next processor period boundary.
REQ-008 halt_ack  out  1  high while halt_req=1 and the block is halted.
REQ-009 cfg_valid  in  1  configuration write valid.
REQ-010 cfg_ready  out  1  configuration write accepted when high together with cfg_valid.
REQ-011 cfg_vga_div  in  DIV_W  VGA divide value; period = value+1 CLK cycles.
REQ-012 cfg_proc_div  in  DIV_W  processor divide value; period = value+1 CLK cycles.
REQ-013 vga_ce  out  1  one-CLK-wide VGA clock-enable pulse.
REQ-014 proc_ce  out  1  one-CLK-wide processor clock-enable pulse.
REQ-015 step_done  out  1  one-cycle pulse in the cycle the STEP state returns to HALTED.
REQ-016 state  out  2  encoding: HALTED=00, RUN=01, STEP=10, DRAIN=11.
REQ-017 tick_cnt  out  TICK_W  count of proc_ce pulses issued; wraps modulo 2^TICK_W.

Function
REQ-018 Registers: vga_div_q, proc_div_q, vcnt (DIV_W), pcnt (DIV_W), state, tick_cnt.
REQ-019 vcnt runs free in every state: it increments each cycle and reloads to 0 in the cycle vcnt==vga_div_q.
REQ-020 vga_ce is high exactly in the cycles where vcnt==vga_div_q, so vga_div_q=0 gives vga_ce high every cycle.
REQ-021 proc_ce = (state!=HALTED) && (pcnt==proc_div_q); it is decoded from registers only, never from inputs.
REQ-022 pcnt behaviour: held at 0 in HALTED; in any other state it increments each cycle and reloads to 0 in proc_ce cycles.
REQ-023 First-pulse latency: the first proc_ce occurs proc_div_q cycles after the first cycle in RUN or STEP, i.e. in the first cycle itself when the value is 0.
REQ-024 HALTED: halt_req=1 keeps the block in HALTED; otherwise run=1 moves to RUN, else step=1 moves to STEP; run takes priority over step.
REQ-025 RUN: halt_req=1 or run=0 moves to DRAIN, but moves directly to HALTED if proc_ce is high in that cycle; otherwise the block stays in RUN.
REQ-026 DRAIN: the block stays until the proc_ce cycle, then moves to HALTED; run reasserting does not cancel the drain.
REQ-027 STEP: the block stays until the proc_ce cycle, then moves to HALTED and pulses step_done in that cycle.
REQ-028 STEP: halt_req and run are ignored until the step completes.
REQ-029 STEP: step held high re-triggers one further STEP per HALTED visit.
REQ-030 cfg_ready = (state==HALTED).
REQ-031 On cfg_valid&&cfg_ready, vga_div_q and proc_div_q load next cycle and vcnt reloads to 0.
REQ-032 A configuration write and an exit from HALTED may occur in the same cycle; the new divide values apply from the next cycle.
REQ-033 tick_cnt increments on every proc_ce, wrapping from 2^TICK_W-1 to 0.
REQ-034 halt_ack is combinational: (state==HALTED) && halt_req.

Reset
REQ-035 On RST=1, asynchronously: state=HALTED, vcnt=0, pcnt=0, tick_cnt=0, vga_div_q=1, proc_div_q=3.
REQ-036 Outputs during reset: vga_ce=0, proc_ce=0, step_done=0, cfg_ready=1, halt_ack=halt_req.
REQ-037 After reset release the defaults give VGA period 2 and processor period 4 CLK cycles.
REQ-038 RST asserted mid-RUN, mid-DRAIN or mid-STEP aborts to HALTED; no proc_ce is issued while RST=1.

Verification
REQ-039 Release reset, run=0 for 8 cycles -> vga_ce every 2nd cycle, proc_ce never, state=00, tick_cnt=0.
REQ-040 Defaults, run=1 from cycle 0 -> state=01 at cycle 1, proc_ce at cycles 4, 8, 12, tick_cnt=3 after cycle 12.
REQ-041 In RUN with pcnt=1, assert halt_req -> state=11, proc_ce 2 cycles later, then state=00 and halt_ack=1; when halt_req coincides with proc_ce the block goes straight to 00.
REQ-042 Halted, write cfg_proc_div=0 and cfg_vga_div=4, then step=1 for one cycle -> one proc_ce in the first STEP cycle, step_done in that same cycle, and vga_ce every 5 cycles.
REQ-043 cfg_valid=1 while in RUN -> cfg_ready=0 and divide values unchanged.
REQ-044 Preload tick_cnt to 16'hFFFF via 65535 pulses at proc_div=0, issue one more pulse -> tick_cnt=0.
REQ-045 Assert RST in DRAIN -> state=00 and pcnt=0 immediately, proc_div_q=3.

Source files
------------

// File: rtl/clk_sched_ctrl.sv
// clk_sched_ctrl: VGA and processor clock-enable generator with run/step/halt sequencing
module clk_sched_ctrl #(
    parameter int DIV_W  = 8,
    parameter int TICK_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              run,
    input  logic              step,
    input  logic              halt_req,
    output logic              halt_ack,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIV_W-1:0]  cfg_vga_div,
    input  logic [DIV_W-1:0]  cfg_proc_div,
    output logic              vga_ce,
    output logic              proc_ce,
    output logic              step_done,
    output logic [1:0]        state,
    output logic [TICK_W-1:0] tick_cnt
);
    typedef enum logic [1:0] {HALTED = 2'b00, RUN = 2'b01, STEP = 2'b10, DRAIN = 2'b11} state_t;
    state_t            state_q, state_d;
    logic [DIV_W-1:0]  vga_div_q, vga_div_d, proc_div_q, proc_div_d;
    logic [DIV_W-1:0]  vcnt_q, vcnt_d, pcnt_q, pcnt_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              cfg_wr;
    assign cfg_ready = state_q == HALTED;
    assign cfg_wr    = cfg_valid && cfg_ready;
    assign vga_ce    = vcnt_q == vga_div_q;
    assign proc_ce   = state_q != HALTED && pcnt_q == proc_div_q;
    assign step_done = state_q == STEP && proc_ce;
    assign halt_ack  = cfg_ready && halt_req;
    assign state     = state_q;
    assign tick_cnt  = tick_q;
    // Leaving an active state only happens on a processor period boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HALTED:  state_d = halt_req ? HALTED : run ? RUN : step ? STEP : HALTED;
            RUN:     state_d = (halt_req || !run) ? (proc_ce ? HALTED : DRAIN) : RUN;
            default: state_d = proc_ce ? HALTED : state_q;
        endcase
    end
    always_comb begin
        vga_div_d  = cfg_wr ? cfg_vga_div : vga_div_q;
        proc_div_d = cfg_wr ? cfg_proc_div : proc_div_q;
        vcnt_d     = (cfg_wr || vga_ce) ? '0 : vcnt_q + 1'b1;
        pcnt_d     = (state_q == HALTED || proc_ce) ? '0 : pcnt_q + 1'b1;
        tick_d     = proc_ce ? tick_q + 1'b1 : tick_q;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= HALTED;
            vga_div_q  <= DIV_W'(1);
            proc_div_q <= DIV_W'(3);
            vcnt_q     <= '0;
            pcnt_q     <= '0;
            tick_q     <= '0;
        end else begin
            state_q    <= state_d;
            vga_div_q  <= vga_div_d;
            proc_div_q <= proc_div_d;
            vcnt_q     <= vcnt_d;
            pcnt_q     <= pcnt_d;
            tick_q     <= tick_d;
        end
    end
endmodule

// File: tb/tb_clk_sched_ctrl.sv
// tb_clk_sched_ctrl: scenario tasks plus randomized traffic against a period-arithmetic model
module tb_clk_sched_ctrl;
    logic        CLK = 1'b0;
    logic        RST, run, step, halt_req, cfg_valid;
    logic [7:0]  cfg_vga_div, cfg_proc_div;
    logic        halt_ack, cfg_ready, vga_ce, proc_ce, step_done;
    logic [1:0]  state;
    logic [15:0] tick_cnt;
    logic [22:0] actv;
    int n_cmp = 0, n_bad = 0;
    int m_mode, m_vdiv, m_pdiv, m_vph, m_pph, m_ticks;

    clk_sched_ctrl #(.DIV_W(8), .TICK_W(16)) dut (
        .CLK(CLK), .RST(RST), .run(run), .step(step), .halt_req(halt_req),
        .halt_ack(halt_ack), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_vga_div(cfg_vga_div), .cfg_proc_div(cfg_proc_div), .vga_ce(vga_ce),
        .proc_ce(proc_ce), .step_done(step_done), .state(state), .tick_cnt(tick_cnt)
    );

    always #5 CLK = ~CLK;
    assign actv = {vga_ce, proc_ce, step_done, cfg_ready, halt_ack, state, tick_cnt};

    // Model: mode 0 halted, 1 run, 2 step, 3 drain; enables come from elapsed-cycle phase arithmetic.
    function automatic logic [22:0] expv();
        logic vce, pce;
        vce = (m_vph % (m_vdiv + 1)) == m_vdiv;
        pce = m_mode != 0 && (m_pph % (m_pdiv + 1)) == m_pdiv;
        return {vce, pce, pce && m_mode == 2, m_mode == 0, m_mode == 0 && halt_req, m_mode[1:0], m_ticks[15:0]};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_vdiv = 1; m_pdiv = 3; m_vph = 0; m_pph = 0; m_ticks = 0;
    endtask

    task automatic model_step();
        logic [22:0] e;
        logic pce;
        int nm;
        e = expv();
        pce = e[21];
        if (m_mode == 0) nm = halt_req ? 0 : run ? 1 : step ? 2 : 0;
        else if (m_mode == 1) nm = (halt_req || !run) ? (pce ? 0 : 3) : 1;
        else nm = pce ? 0 : m_mode;
        if (m_mode == 0 && cfg_valid) begin
            m_vdiv = cfg_vga_div; m_pdiv = cfg_proc_div; m_vph = 0;
        end else m_vph++;
        m_pph = (m_mode == 0) ? 0 : m_pph + 1;
        if (pce) m_ticks = (m_ticks + 1) % 65536;
        m_mode = nm;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST) model_reset(); else model_step();
        @(negedge CLK);
    endtask

    task automatic drive(input logic r, input logic s, input logic h);
        run = r; step = s; halt_req = h;
    endtask

    task automatic do_reset();
        RST = 1'b1; cfg_valid = 1'b0; drive(0, 0, 0); model_reset();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; cfg_valid = 1'b0; cfg_vga_div = '0; cfg_proc_div = '0; drive(0, 0, 1); model_reset();
        #1 n_cmp++;
        if (actv !== expv()) begin n_bad++; $display("FAIL reset_model: got %h want %h", actv, expv()); end
        n_cmp++;
        if (actv !== {5'b00011, 2'b00, 16'h0000}) begin n_bad++; $display("FAIL reset_outputs: got %h want %h", actv, {5'b00011, 18'h0}); end
        tick();
        halt_req = 1'b0;
        #1 n_cmp++;
        if (halt_ack !== 1'b0) begin n_bad++; $display("FAIL reset_halt_ack: got %b want 0", halt_ack); end
        RST = 1'b0;
    endtask

    task automatic test_idle();
        int nv = 0, np = 0;
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 0);
            #1 n_cmp++;
            if (actv !== expv()) begin n_bad++; $display("FAIL idle_model c%0d: got %h want %h", c, actv, expv()); end
            nv += int'(vga_ce); np += int'(proc_ce);
            tick();
        end
        #1 n_cmp++;
        if (nv != 4 || np != 0 || state !== 2'b00 || tick_cnt !== 16'h0) begin
            n_bad++; $display("FAIL idle_counts: vga %0d proc %0d state %b tick %0d want 4 0 00 0", nv, np, state, tick_cnt);
        end
    endtask

    task automatic test_run();
        logic ep;
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            drive(1, 0, 0);
            ep = c == 4 || c == 8 || c == 12;
            #1 n_cmp++;
            if (actv !== expv()) begin n_bad++; $display("FAIL run_model c%0d: got %h want %h", c, actv, expv()); end
            n_cmp++;
            if (proc_ce !== ep) begin n_bad++; $display("FAIL run_proc_ce c%0d: got %b want %b", c, proc_ce, ep); end
            if (c == 1) begin
                n_cmp++;
                if (state !== 2'b01) begin n_bad++; $display("FAIL run_state: got %b want 01", state); end
            end
            tick();
        end
        #1 n_cmp++;
        if (tick_cnt !== 16'd3) begin n_bad++; $display("FAIL run_ticks: got %0d want 3", tick_cnt); end
    endtask

    task automatic test_halt();
        for (int c = 13; c <= 17; c++) begin
            drive(1, 0, c >= 14);
            #1 n_cmp++;
            if (actv !== expv()) begin n_bad++; $display("FAIL halt_model c%0d: got %h want %h", c, actv, expv()); end
            n_cmp++;
            if (c == 15 && (state !== 2'b11 || proc_ce !== 1'b0)) begin n_bad++; $display("FAIL halt_drain: state %b ce %b want 11 0", state, proc_ce); end
            else if (c == 16 && proc_ce !== 1'b1) begin n_bad++; $display("FAIL halt_last_ce: got %b want 1", proc_ce); end
            else if (c == 17 && (state !== 2'b00 || halt_ack !== 1'b1)) begin n_bad++; $display("FAIL halt_ack: state %b ack %b want 00 1", state, halt_ack); end
            tick();
        end
        for (int c = 0; c < 6; c++) begin
            drive(1, 0, c >= 4);
            #1 n_cmp++;
            if (actv !== expv()) begin n_bad++; $display("FAIL halt_coincide_model c%0d: got %h want %h", c, actv, expv()); end
            n_cmp++;
            if (c == 4 && proc_ce !== 1'b1) begin n_bad++; $display("FAIL halt_coincide_ce: got %b want 1", proc_ce); end
            else if (c == 5 && state !== 2'b00) begin n_bad++; $display("FAIL halt_coincide_state: got %b want 00", state); end
            tick();
        end
    endtask

    task automatic test_step_cfg();
        int nv = 0, nd = 0;
        drive(0, 0, 0); cfg_valid = 1'b1; cfg_vga_div = 8'd4; cfg_proc_div = 8'd0;
        #1 n_cmp++;
        if (actv !== expv()) begin n_bad++; $display("FAIL cfg_write_model: got %h want %h", actv, expv()); end
        tick();
        cfg_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(0, c == 0, 0);
            #1 n_cmp++;
            if (actv !== expv()) begin n_bad++; $display("FAIL step_model c%0d: got %h want %h", c, actv, expv()); end
            n_cmp++;
            if (c == 1 && {proc_ce, step_done, state} !== 4'b1110) begin n_bad++; $display("FAIL step_pulse: ce/done/state %b want 1110", {proc_ce, step_done, state}); end
            else if (c == 2 && {proc_ce, state} !== 3'b000) begin n_bad++; $display("FAIL step_return: ce/state %b want 000", {proc_ce, state}); end
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            #1 n_cmp++;
            if (actv !== expv()) begin n_bad++; $display("FAIL vga5_model c%0d: got %h want %h", c, actv, expv()); end
            nv += int'(vga_ce);
            tick();
        end
        for (int c = 0; c < 6; c++) begin
            drive(0, 1, 0);
            #1 n_cmp++;
            if (actv !== expv()) begin n_bad++; $display("FAIL step_held_model c%0d: got %h want %h", c, actv, expv()); end
            nd += int'(step_done);
            tick();
        end
        drive(0, 0, 0);
        #1 n_cmp++;
        if (nv != 4 || nd != 3) begin n_bad++; $display("FAIL step_counts: vga %0d done %0d want 4 3", nv, nd); end
    endtask

    task automatic test_cfg_in_run();
        int np = 0, nv = 0;
        drive(1, 0, 0);
        #1 tick();
        for (int c = 0; c < 4; c++) begin
            drive(1, 0, 0); cfg_valid = 1'b1; cfg_vga_div = 8'd7; cfg_proc_div = 8'd7;
            #1 n_cmp++;
            if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL run_cfg_ready: got %b want 0", cfg_ready); end
            np += int'(proc_ce);
            tick();
        end
        cfg_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, 0);
            #1 n_cmp++;
            if (actv !== expv()) begin n_bad++; $display("FAIL run_cfg_model c%0d: got %h want %h", c, actv, expv()); end
            nv += int'(vga_ce);
            tick();
        end
        #1 n_cmp++;
        if (np != 4 || nv != 2) begin n_bad++; $display("FAIL run_cfg_unchanged: proc %0d vga %0d want 4 2", np, nv); end
    endtask

    task automatic test_tick_wrap();
        do_reset();
        drive(0, 0, 0); cfg_valid = 1'b1; cfg_vga_div = 8'd0; cfg_proc_div = 8'd0;
        #1 tick();
        cfg_valid = 1'b0;
        drive(1, 0, 0);
        #1 tick();
        for (int c = 0; c < 65535; c++) tick();
        drive(0, 0, 0);
        #1 n_cmp++;
        if (tick_cnt !== 16'hFFFF || proc_ce !== 1'b1 || actv !== expv()) begin
            n_bad++; $display("FAIL wrap_preload: tick %h ce %b want ffff 1", tick_cnt, proc_ce);
        end
        tick();
        #1 n_cmp++;
        if (tick_cnt !== 16'h0000 || state !== 2'b00 || actv !== expv()) begin
            n_bad++; $display("FAIL wrap_zero: tick %h state %b want 0000 00", tick_cnt, state);
        end
    endtask

    task automatic test_rst_drain();
        do_reset();
        drive(1, 0, 0);
        #1 tick();
        drive(0, 0, 0);
        #1 tick();
        #1 n_cmp++;
        if (state !== 2'b11) begin n_bad++; $display("FAIL drain_entry: got %b want 11", state); end
        RST = 1'b1; model_reset();
        #1 n_cmp++;
        if ({state, proc_ce, cfg_ready} !== 4'b0001 || actv !== expv()) begin
            n_bad++; $display("FAIL drain_async_reset: state/ce/rdy %b want 0001", {state, proc_ce, cfg_ready});
        end
        tick();
        RST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(1, 0, 0);
            #1 n_cmp++;
            if (proc_ce !== (c == 4) || actv !== expv()) begin
                n_bad++; $display("FAIL drain_after_reset c%0d: ce %b want %b", c, proc_ce, c == 4);
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) run = ~run;
            step = $urandom_range(0, 2) == 0;
            halt_req = $urandom_range(0, 5) == 0;
            cfg_valid = $urandom_range(0, 3) == 0;
            cfg_vga_div = 8'($urandom_range(0, 5));
            cfg_proc_div = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 299) == 0) begin RST = 1'b1; model_reset(); end
            #1 n_cmp++;
            if (actv !== expv()) begin n_bad++; $display("FAIL random_model i%0d: got %h want %h", i, actv, expv()); end
            tick();
            RST = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_run();
        test_halt();
        test_step_cfg();
        test_cfg_in_run();
        test_tick_wrap();
        test_rst_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
